// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        DRAIN,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid marks the byte completing a word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic [7:0]  byte_in,
    input  logic        shift_en,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [31:0] sr;

    // Incoming bytes enter at the top so the first byte ends up in bits [7:0].
    assign word       = {byte_in, sr[31:8]};
    assign word_valid = shift_en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 2'd1;
            sr  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the core in reset until complete.
//
// state  | meaning
// HDR_LO | waiting for word-count low byte
// HDR_HI | waiting for word-count high byte, range check
// DATA   | packing payload bytes and writing words
// DRAIN  | final write strobe in flight
// DONE   | image loaded, core released
// ERROR  | word count too large, bytes swallowed
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int                    HDR_W    = 8 * HDR_BYTES;
    localparam logic [CNT_WIDTH-1:0]  CAPACITY = CNT_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WL_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                 state, state_nxt;
    logic [7:0]             hdr_lo;
    logic [CNT_WIDTH-1:0]   n_words;
    logic [CNT_WIDTH-1:0]   hdr_n;
    logic                   xfer, restart, last_word;
    logic                   pk_valid, pk_clear, pk_shift;
    logic [31:0]            pk_word;

    assign xfer      = rx_valid && rx_ready;
    assign hdr_n     = CNT_WIDTH'(HDR_W'({rx_data, hdr_lo}));
    assign restart   = load_req && ((state == DONE) || (state == ERROR));
    assign last_word = (CNT_WIDTH'(words_loaded) + CNT_ONE) == n_words;
    assign pk_shift  = xfer && (state == DATA);
    assign pk_clear  = !reset || (state != DATA);

    byte_packer u_packer (
        .clk        (clk),
        .byte_in    (rx_data),
        .shift_en   (pk_shift),
        .clear      (pk_clear),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= HDR_LO;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR_LO: if (xfer) state_nxt = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    if (hdr_n > CAPACITY)  state_nxt = ERROR;
                    else if (hdr_n == '0)  state_nxt = DONE;
                    else                   state_nxt = DATA;
                end
            end
            DATA:   if (pk_valid && last_word) state_nxt = DRAIN;
            DRAIN:  state_nxt = DONE;
            DONE:   if (load_req) state_nxt = HDR_LO;
            ERROR:  if (load_req) state_nxt = HDR_LO;
            default: state_nxt = HDR_LO;
        endcase
    end

    always_comb begin
        rx_ready   = 1'b0;
        core_reset = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            HDR_LO, HDR_HI, DATA: rx_ready = 1'b1;
            DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            ERROR: begin
                rx_ready = 1'b1;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // The address holds on the last word so a full-capacity image never wraps to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            hdr_lo       <= '0;
            n_words      <= '0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                words_loaded <= '0;
                imem_addr    <= '0;
            end else begin
                if ((state == HDR_LO) && xfer) hdr_lo  <= rx_data;
                if ((state == HDR_HI) && xfer) n_words <= hdr_n;
                if (pk_valid) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= pk_word;
                end
                if (imem_we) begin
                    words_loaded <= words_loaded + WL_ONE;
                    if (state != DRAIN) imem_addr <= imem_addr + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, packing, gaps, errors, reload and full capacity.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          load_req = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            last_we_cyc = -1;
    int            fall_cyc    = -1;
    int            dbl_strobe  = 0;
    logic          prev_we = 1'b0;
    logic          prev_cr = 1'b1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            last_we_cyc = cyc;
            if (prev_we) dbl_strobe++;
        end
        if (prev_cr && !core_reset) fall_cyc = cyc;
        prev_we = imem_we;
        prev_cr = core_reset;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (wa_q.size() > idx) begin
            chk($sformatf("wr%0d_addr", idx), 32'(wa_q[idx]), addr);
            chk($sformatf("wr%0d_data", idx), wd_q[idx], data);
        end else begin
            chk($sformatf("wr%0d_missing", idx), 32'(wa_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            int k;
            k = $urandom_range(0, 3);
            rx_valid = 1'b0;
            repeat (k) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 20) chk("send_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        dbl_strobe  = 0;
        fall_cyc    = -1;
        last_we_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_two_word_image(input string pfx);
        chk({pfx, "_nwr"}, 32'(wa_q.size()), 32'd2);
        chk_write(0, 32'd0, 32'h0050_0093);
        chk_write(1, 32'd1, 32'h0000_0113);
        chk({pfx, "_words"}, 32'(words_loaded), 32'd2);
        chk({pfx, "_done"}, 32'(done), 32'd1);
        chk({pfx, "_core_rst"}, 32'(core_reset), 32'd0);
        chk({pfx, "_rel_lag"}, 32'(fall_cyc - last_we_cyc), 32'd1);
        chk({pfx, "_dbl"}, 32'(dbl_strobe), 32'd0);
    endtask

    logic [7:0] s_two[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00};
    logic [7:0] s_part[$] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] s_beef[$] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] s_reld[$] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] s_cap[$];

    initial begin
        int bad;

        // Reset state and idle
        do_reset();
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_core_rst", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_nwr", 32'(wa_q.size()), 32'd0);
        chk("idle_core_rst", 32'(core_reset), 32'd1);

        // Continuous two-word image
        send_stream(s_two, 1'b0);
        repeat (3) @(negedge clk);
        check_two_word_image("cont");
        chk("done_ready", 32'(rx_ready), 32'd0);

        // Bytes offered in DONE are not taken
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("done_bp_nwr", 32'(wa_q.size()), 32'd2);
        chk("done_bp_done", 32'(done), 32'd1);

        // Same image with random gaps
        do_reset();
        send_stream(s_two, 1'b1);
        repeat (3) @(negedge clk);
        check_two_word_image("gap");

        // Zero-length image
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("n0_done", 32'(done), 32'd1);
        chk("n0_core_rst", 32'(core_reset), 32'd0);
        repeat (2) @(negedge clk);
        chk("n0_nwr", 32'(wa_q.size()), 32'd0);

        // Oversized header then restart
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_core_rst", 32'(core_reset), 32'd1);
        chk("err_done", 32'(done), 32'd0);
        send_stream(s_beef, 1'b0);
        repeat (2) @(negedge clk);
        chk("err_nwr", 32'(wa_q.size()), 32'd0);
        chk("err_ready", 32'(rx_ready), 32'd1);
        pulse_load_req();
        chk("err_rl_error", 32'(error), 32'd0);
        chk("err_rl_ready", 32'(rx_ready), 32'd1);
        chk("err_rl_core_rst", 32'(core_reset), 32'd1);

        // Reset mid-load discards the partial word
        do_reset();
        send_stream(s_part, 1'b0);
        repeat (2) @(negedge clk);
        chk("part_nwr", 32'(wa_q.size()), 32'd1);
        chk_write(0, 32'd0, 32'h4433_2211);
        do_reset();
        send_stream(s_beef, 1'b0);
        repeat (3) @(negedge clk);
        chk("beef_nwr", 32'(wa_q.size()), 32'd1);
        chk_write(0, 32'd0, 32'hDEAD_BEEF);
        chk("beef_done", 32'(done), 32'd1);
        chk("beef_words", 32'(words_loaded), 32'd1);

        // Reload after DONE
        pulse_load_req();
        chk("rl_core_rst", 32'(core_reset), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_addr", 32'(imem_addr), 32'd0);
        chk("rl_words", 32'(words_loaded), 32'd0);
        clear_log();
        send_stream(s_reld, 1'b0);
        repeat (3) @(negedge clk);
        chk("rl_nwr", 32'(wa_q.size()), 32'd1);
        chk_write(0, 32'd0, 32'h1234_5678);
        chk("rl_done2", 32'(done), 32'd1);
        chk("rl_core_rst2", 32'(core_reset), 32'd0);

        // Full-capacity image: word i is byte i repeated
        do_reset();
        s_cap.push_back(8'h00);
        s_cap.push_back(8'h01);
        for (int i = 0; i < 256; i++) repeat (4) s_cap.push_back(8'(i));
        send_stream(s_cap, 1'b0);
        repeat (3) @(negedge clk);
        chk("cap_nwr", 32'(wa_q.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] !== 8'(i) || wd_q[i] !== {4{8'(i)}}) bad++;
        end
        chk("cap_bad", 32'(bad), 32'd0);
        chk("cap_done", 32'(done), 32'd1);
        chk("cap_words", 32'(words_loaded), 32'd256);
        chk("cap_addr", 32'(imem_addr), 32'd255);
        chk("cap_dbl", 32'(dbl_strobe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
